// File: rtl/ahb_mtx_out_arb_pkg.sv
// Shared constants and types for the bus-matrix output-port arbiters.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ahb_mtx_out_arb_pkg;

    localparam int NUM_IN = 3;
    localparam int IDX_W  = 2;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Next input index in round-robin order, wrapping NUM_IN-1 -> 0.
    // Out-of-range indices also wrap to 0 so the search always starts somewhere legal.
    function automatic idx_t rr_next(input idx_t i);
        return (i >= idx_t'(NUM_IN - 1)) ? idx_t'(0) : i + idx_t'(1);
    endfunction

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found_o=0 when no request is set (idx_o is then 0).
//
// Ports:
//   req_i   - per-input request vector
//   last_i  - index of the most recent winner; search starts at last_i+1
//   idx_o   - winning index
//   found_o - at least one request was set
module ahb_mtx_rr_pick
    import ahb_mtx_out_arb_pkg::*;
(
    input  logic [NUM_IN-1:0] req_i,
    input  idx_t              last_i,
    output idx_t              idx_o,
    output logic              found_o
);

    idx_t cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = rr_next(last_i);
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/ahb_mtx_out_arb.sv
// Round-robin arbiter/sequencer for one bus-matrix output port shared by three inputs.
// Latency: 0-cycle address grant; data-phase owner follows one HREADYM-accepted cycle later.
// Backpressure: HREADYM=0 freezes the grant and all state; bursts and locked sequences keep ownership.
//
// Ports:
//   HCLK, HRESETn - clock and asynchronous active-low reset
//   req_in        - per-input select for this output port
//   trans_in      - per-input HTRANS, input i on bits [2i+1:2i]
//   lock_in       - per-input HMASTLOCK
//   HREADYM       - output port HREADY (address phase accepted / data phase done)
//   addr_sel      - input driving the output address phase
//   addr_valid    - HSEL toward the output port
//   data_sel      - input owning the current data phase
//   data_valid    - current data phase is a real (NONSEQ/SEQ) transfer
//   active_out    - one-hot grant returned to each input decoder
//   HMASTLOCKM    - lock qualifier toward the output port
module ahb_mtx_out_arb
    import ahb_mtx_out_arb_pkg::*;
#(
    parameter int unsigned PARK_IDX = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [NUM_IN-1:0]   req_in,
    input  logic [2*NUM_IN-1:0] trans_in,
    input  logic [NUM_IN-1:0]   lock_in,
    input  logic                HREADYM,
    output logic [IDX_W-1:0]    addr_sel,
    output logic                addr_valid,
    output logic [IDX_W-1:0]    data_sel,
    output logic                data_valid,
    output logic [NUM_IN-1:0]   active_out,
    output logic                HMASTLOCKM
);

    localparam idx_t PARK = idx_t'(PARK_IDX);
    localparam idx_t LAST_RST = idx_t'(NUM_IN - 1);

    idx_t owner_q, owner_d;
    idx_t last_q, last_d;
    idx_t data_sel_q, data_sel_d;
    logic hold_q, hold_d;
    logic data_valid_q, data_valid_d;

    logic [1:0] trans_a [NUM_IN];
    logic       owner_busy;
    logic       hold;
    idx_t       rr_idx;
    logic       rr_found;
    idx_t       grant;
    logic       grant_vld;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            trans_a[i] = trans_in[2*i +: 2];
        end
    end

    ahb_mtx_rr_pick u_pick (
        .req_i   (req_in),
        .last_i  (last_q),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

    // The owner keeps the port while it is mid-burst (BUSY/SEQ have bit 0 set)
    // or locked; hold_q carries a lock across a trailing IDLE.
    assign owner_busy = req_in[owner_q] & (trans_a[owner_q][0] | lock_in[owner_q]);
    assign hold       = hold_q | owner_busy;

    // While the output port waits, the address phase on the bus must not move,
    // so the grant is pinned to the owner regardless of request changes.
    always_comb begin
        grant = owner_q;
        if (HREADYM && !hold && rr_found) begin
            grant = rr_idx;
        end
    end

    // Outputs are quiesced while reset is asserted so no input sees a transfer
    // start before the state registers are released.
    assign grant_vld  = HRESETn & req_in[grant];
    assign addr_sel   = HRESETn ? grant : PARK;
    assign addr_valid = grant_vld;
    assign active_out = grant_vld ? (NUM_IN'(1) << grant) : '0;
    assign HMASTLOCKM = grant_vld & lock_in[grant];
    assign data_sel   = data_sel_q;
    assign data_valid = data_valid_q;

    always_comb begin
        owner_d      = owner_q;
        last_d       = last_q;
        hold_d       = hold_q;
        data_sel_d   = data_sel_q;
        data_valid_d = data_valid_q;
        if (HREADYM) begin
            owner_d = grant;
            // Only a burst start moves the rotation pointer.
            if (grant_vld && (trans_a[grant] == HTRANS_NONSEQ)) begin
                last_d = grant;
            end
            hold_d       = grant_vld & lock_in[grant];
            data_sel_d   = grant;
            data_valid_d = grant_vld & trans_a[grant][1];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q      <= PARK;
            last_q       <= LAST_RST;
            hold_q       <= 1'b0;
            data_sel_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            data_sel_q   <= data_sel_d;
            data_valid_q <= data_valid_d;
        end
    end

endmodule
